bp_fe_queue_pair_tx: RTL and testbench

BP_FE_QUEUE_PAIR_TX -- requirements
Module: bp_fe_queue_pair_tx

---
 rtl/bp_fe_queue_pair_tx.sv | 111 +++++++++++
 tb/tb_bp_fe_queue_pair_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_queue_pair_tx.sv
// rtl/bp_fe_queue_pair_tx.sv - frontend-to-backend skid buffer that issues fetch entries in program-ordered pairs
module bp_fe_queue_pair_tx #(
    parameter int fe_queue_width_p = 128,
    parameter int buf_els_p        = 4,
    parameter int hold_cycles_p    = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic [fe_queue_width_p-1:0] fe_queue_i,
    input  logic                        fe_queue_excp_i,
    input  logic                        fe_queue_v_i,
    output logic                        fe_queue_ready_o,
    output logic [fe_queue_width_p-1:0] fe_queue1_o,
    output logic [fe_queue_width_p-1:0] fe_queue2_o,
    output logic                        fe_queue_v1_o,
    output logic                        fe_queue_v2_o,
    input  logic                        fe_queue_ready_i
);

    localparam int IW = (buf_els_p < 2) ? 1 : $clog2(buf_els_p);
    localparam int PW = IW + 1;
    localparam int WW = (hold_cycles_p < 2) ? 1 : $clog2(hold_cycles_p + 1);
    localparam logic [PW-1:0] NUM      = PW'(buf_els_p);
    localparam logic [IW-1:0] LAST     = IW'(buf_els_p - 1);
    localparam logic [WW-1:0] HOLD_MAX = WW'(hold_cycles_p);

    typedef enum logic [1:0] {IDLE, HOLD, SEND} state_e;

    // Pointers are {wrap, index}; the index wraps modulo buf_els_p so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p[IW-1:0] == LAST) return {~p[PW-1], {IW{1'b0}}};
        return {p[PW-1], p[IW-1:0] + IW'(1)};
    endfunction

    function automatic logic [PW-1:0] count_of(input logic [PW-1:0] w, input logic [PW-1:0] r);
        if (w[PW-1] == r[PW-1]) return {1'b0, w[IW-1:0]} - {1'b0, r[IW-1:0]};
        return NUM + {1'b0, w[IW-1:0]} - {1'b0, r[IW-1:0]};
    endfunction

    logic [fe_queue_width_p-1:0] mem_q [buf_els_p];
    logic                        excp_q [buf_els_p];

    state_e        state_q, state_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          lone_q, lone_d;

    logic [PW-1:0] count_r, count_d, rnext;
    logic          push, pop, pair_ok, head_excp_d;
    logic [IW-1:0] ridx_d;

    always_comb begin
        count_r          = count_of(wptr_q, rptr_q);
        rnext            = ptr_inc(rptr_q);
        fe_queue_ready_o = reset_i & ~flush_i & (count_r != NUM);
        push             = fe_queue_v_i & fe_queue_ready_o;
        // A lone entry already offered under backpressure stays lone until taken.
        pair_ok          = (count_r >= PW'(2)) & ~excp_q[rptr_q[IW-1:0]]
                           & ~excp_q[rnext[IW-1:0]] & ~lone_q;
        fe_queue_v1_o    = (state_q == SEND) & ~flush_i;
        fe_queue_v2_o    = fe_queue_v1_o & pair_ok;
        fe_queue1_o      = mem_q[rptr_q[IW-1:0]];
        fe_queue2_o      = mem_q[rnext[IW-1:0]];
        pop              = fe_queue_v1_o & fe_queue_ready_i;

        rptr_d = rptr_q;
        if (flush_i)            rptr_d = wptr_q;
        else if (pop)           rptr_d = fe_queue_v2_o ? ptr_inc(rnext) : rnext;
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        count_d = count_of(wptr_d, rptr_d);

        wait_d = '0;
        if (!flush_i && !push && state_q == HOLD)
            wait_d = (wait_q == HOLD_MAX) ? wait_q : wait_q + WW'(1);

        lone_d = fe_queue_v1_o & ~fe_queue_v2_o & ~fe_queue_ready_i;

        ridx_d      = rptr_d[IW-1:0];
        head_excp_d = (push && wptr_q[IW-1:0] == ridx_d) ? fe_queue_excp_i : excp_q[ridx_d];

        state_d = SEND;
        if (fe_queue_v1_o && !fe_queue_ready_i)                          state_d = SEND;
        else if (count_d == '0)                                          state_d = IDLE;
        else if (count_d == PW'(1) && !head_excp_d && wait_d < HOLD_MAX) state_d = HOLD;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            rptr_q  <= '0;
            wptr_q  <= '0;
            wait_q  <= '0;
            lone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            wait_q  <= wait_d;
            lone_q  <= lone_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[IW-1:0]]  <= fe_queue_i;
            excp_q[wptr_q[IW-1:0]] <= fe_queue_excp_i;
        end
    end

endmodule

// File: tb/tb_bp_fe_queue_pair_tx.sv
// tb/tb_bp_fe_queue_pair_tx.sv - scoreboard bench for bp_fe_queue_pair_tx
module tb_bp_fe_queue_pair_tx;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         flush_i = 1'b0;
    logic [W-1:0] fe_queue_i = '0;
    logic         fe_queue_excp_i = 1'b0;
    logic         fe_queue_v_i = 1'b0;
    logic         fe_queue_ready_o;
    logic [W-1:0] fe_queue1_o, fe_queue2_o;
    logic         fe_queue_v1_o, fe_queue_v2_o;
    logic         fe_queue_ready_i = 1'b1;

    always #5 clk_i = ~clk_i;

    bp_fe_queue_pair_tx #(.fe_queue_width_p(W), .buf_els_p(4), .hold_cycles_p(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .fe_queue_i(fe_queue_i), .fe_queue_excp_i(fe_queue_excp_i), .fe_queue_v_i(fe_queue_v_i),
        .fe_queue_ready_o(fe_queue_ready_o),
        .fe_queue1_o(fe_queue1_o), .fe_queue2_o(fe_queue2_o),
        .fe_queue_v1_o(fe_queue_v1_o), .fe_queue_v2_o(fe_queue_v2_o),
        .fe_queue_ready_i(fe_queue_ready_i)
    );

    typedef struct packed {
        logic [W-1:0] d1;
        logic         v2;
        logic [W-1:0] d2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_out(input logic [W-1:0] d1, input logic v2, input logic [W-1:0] d2);
        exp_q.push_back('{d1: d1, v2: v2, d2: d2});
    endtask

    // Monitor: pops the scoreboard on every accepted issue and checks stall stability.
    logic         prev_hold = 1'b0;
    logic         prev_v2;
    logic [W-1:0] prev_d1, prev_d2;
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_i) begin
            prev_hold = 1'b0;
        end else begin
            if (fe_queue_v2_o) chk("v2_implies_v1", W'(fe_queue_v1_o), W'(1));
            if (prev_hold && !flush_i) begin
                chk("stall_v1", W'(fe_queue_v1_o), W'(1));
                chk("stall_v2", W'(fe_queue_v2_o), W'(prev_v2));
                chk("stall_d1", fe_queue1_o, prev_d1);
                if (prev_v2) chk("stall_d2", fe_queue2_o, prev_d2);
            end
            if (fe_queue_v1_o && fe_queue_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue actual=%0h/%0b required=none", fe_queue1_o, fe_queue_v2_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("slot1", fe_queue1_o, e.d1);
                    chk("v2", W'(fe_queue_v2_o), W'(e.v2));
                    if (e.v2) chk("slot2", fe_queue2_o, e.d2);
                end
            end
            prev_hold = fe_queue_v1_o && !fe_queue_ready_i;
            prev_v2   = fe_queue_v2_o;
            prev_d1   = fe_queue1_o;
            prev_d2   = fe_queue2_o;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic e);
        int n;
        n = 0;
        fe_queue_i      = d;
        fe_queue_excp_i = e;
        fe_queue_v_i    = 1'b1;
        @(negedge clk_i);
        while (!fe_queue_ready_o && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=ready_low required=ready_high");
        end
        @(posedge clk_i);
        #1;
        fe_queue_v_i    = 1'b0;
        fe_queue_excp_i = 1'b0;
    endtask

    initial begin
        cyc(1);
        chk("rst_ready", W'(fe_queue_ready_o), W'(0));
        chk("rst_v1", W'(fe_queue_v1_o), W'(0));
        cyc(1);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", W'(fe_queue_ready_o), W'(1));
        chk("post_rst_v1", W'(fe_queue_v1_o), W'(0));
        cyc(1);

        // Pairing
        expect_out(32'hA0, 1'b1, 32'hB0);
        push(32'hA0, 1'b0);
        push(32'hB0, 1'b0);
        @(negedge clk_i);
        chk("pair_v1", W'(fe_queue_v1_o), W'(1));
        chk("pair_v2", W'(fe_queue_v2_o), W'(1));
        cyc(1);
        @(negedge clk_i);
        chk("pair_empty_v1", W'(fe_queue_v1_o), W'(0));
        cyc(2);

        // Timeout of a lone entry, then a partner arriving during HOLD
        expect_out(32'hA1, 1'b0, 32'h0);
        push(32'hA1, 1'b0);
        @(negedge clk_i);
        chk("hold_c1_v1", W'(fe_queue_v1_o), W'(0));
        @(negedge clk_i);
        chk("hold_c2_v1", W'(fe_queue_v1_o), W'(0));
        @(negedge clk_i);
        chk("timeout_v1", W'(fe_queue_v1_o), W'(1));
        chk("timeout_v2", W'(fe_queue_v2_o), W'(0));
        cyc(3);
        expect_out(32'hA2, 1'b1, 32'hB2);
        push(32'hA2, 1'b0);
        cyc(1);
        push(32'hB2, 1'b0);
        cyc(4);

        // Exception entries issue alone
        expect_out(32'hA3, 1'b0, 32'h0);
        expect_out(32'hE3, 1'b0, 32'h0);
        expect_out(32'hB3, 1'b0, 32'h0);
        push(32'hA3, 1'b0);
        push(32'hE3, 1'b1);
        push(32'hB3, 1'b0);
        cyc(10);

        // Backpressure and full
        fe_queue_ready_i = 1'b0;
        expect_out(32'h1, 1'b1, 32'h2);
        expect_out(32'h3, 1'b1, 32'h4);
        expect_out(32'h5, 1'b0, 32'h0);
        push(32'h1, 1'b0);
        push(32'h2, 1'b0);
        push(32'h3, 1'b0);
        push(32'h4, 1'b0);
        fe_queue_i   = 32'h5;
        fe_queue_v_i = 1'b1;
        @(negedge clk_i);
        chk("full_ready_a", W'(fe_queue_ready_o), W'(0));
        cyc(1);
        @(negedge clk_i);
        chk("full_ready_b", W'(fe_queue_ready_o), W'(0));
        cyc(1);
        fe_queue_ready_i = 1'b1;
        push(32'h5, 1'b0);
        cyc(8);

        // Flush with a concurrent valid input
        fe_queue_ready_i = 1'b0;
        push(32'hC1, 1'b0);
        push(32'hC2, 1'b0);
        push(32'hC3, 1'b0);
        flush_i      = 1'b1;
        fe_queue_i   = 32'hCC;
        fe_queue_v_i = 1'b1;
        @(negedge clk_i);
        chk("flush_v1", W'(fe_queue_v1_o), W'(0));
        chk("flush_v2", W'(fe_queue_v2_o), W'(0));
        chk("flush_ready", W'(fe_queue_ready_o), W'(0));
        cyc(1);
        flush_i          = 1'b0;
        fe_queue_v_i     = 1'b0;
        fe_queue_ready_i = 1'b1;
        @(negedge clk_i);
        chk("post_flush_v1", W'(fe_queue_v1_o), W'(0));
        chk("post_flush_ready", W'(fe_queue_ready_o), W'(1));
        cyc(6);

        // Asynchronous reset between clock edges while a pair is stalled
        fe_queue_ready_i = 1'b0;
        push(32'hD1, 1'b0);
        push(32'hD2, 1'b0);
        #2;
        reset_i = 1'b0;
        #1;
        chk("async_rst_v1", W'(fe_queue_v1_o), W'(0));
        chk("async_rst_v2", W'(fe_queue_v2_o), W'(0));
        chk("async_rst_ready", W'(fe_queue_ready_o), W'(0));
        @(negedge clk_i);
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rel_ready", W'(fe_queue_ready_o), W'(1));
        chk("rel_v1", W'(fe_queue_v1_o), W'(0));
        cyc(1);
        fe_queue_ready_i = 1'b1;
        cyc(6);

        chk("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
